// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), worked through
// BITS_PER_CYCLE bits per clock, LSB chunk first. The borrow between chunks is
// registered, so the critical path is one BITS_PER_CYCLE-wide subtract.
//
// Parameters
//   WIDTH           operand/result width (>= 2)
//   BITS_PER_CYCLE  bits per RUN cycle; must divide WIDTH exactly
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands a/b/bin valid          (input handshake)
//   in_ready   block can accept operands       (input handshake)
//   a, b, bin  minuend, subtrahend, borrow-in
//   out_valid  result valid                    (output handshake)
//   out_ready  consumer accepts result         (output handshake)
//   diff       a - b - bin, low WIDTH bits
//   bout       borrow-out (unsigned a < b + bin)
//   busy       operation in progress (RUN)
//   ovf        signed overflow, only with SERIAL_SUBTRACTOR_OVF_EN defined
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid is never withdrawn before the transfer; payload is stable while
// valid is high and ready is low. in_ready is high only in IDLE and out_valid
// only in DONE, so the two transfers can never overlap.
//
// The state register (state_q) is kept as a plain enum so checkers can bind to
// it hierarchically; in_ready/busy/out_valid are direct decodes of it.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  // Reject configurations that cannot be sliced into whole chunks.
  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $fatal(1, "serial_subtractor: BITS_PER_CYCLE must divide WIDTH (WIDTH>=2)");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    borrow_q;
  logic [WIDTH-1:0]        a_q;
  logic [WIDTH-1:0]        b_q;
  logic [WIDTH-1:0]        res_q;     // partial result being assembled
  logic [WIDTH-1:0]        diff_q;    // published result, held between ops
  logic                    bout_q;

  // Chunk datapath
  logic [BITS_PER_CYCLE-1:0] a_chunk;
  logic [BITS_PER_CYCLE-1:0] b_chunk;
  logic [BITS_PER_CYCLE:0]   chunk_full;
  logic                      borrow_d;
  logic [WIDTH-1:0]          res_d;
  int                        base;

  always_comb begin
    base    = int'(cnt_q) * BITS_PER_CYCLE;
    a_chunk = a_q[base +: BITS_PER_CYCLE];
    b_chunk = b_q[base +: BITS_PER_CYCLE];
    // Zero-extended subtract: the extra top bit goes to 1 exactly when the
    // chunk result is negative, which is the borrow into the next chunk.
    chunk_full = {1'b0, a_chunk} - {1'b0, b_chunk}
               - {{BITS_PER_CYCLE{1'b0}}, borrow_q};
    borrow_d   = chunk_full[BITS_PER_CYCLE];
    res_d      = res_q;
    res_d[base +: BITS_PER_CYCLE] = chunk_full[BITS_PER_CYCLE-1:0];
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_q;
  logic ovf_d;
  // Signed overflow: operands of opposite sign and the result sign differs
  // from the minuend's sign.
  always_comb begin
    ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // in_ready is the IDLE decode, so in_valid alone completes the handshake.
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          res_q    <= res_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            diff_q  <= res_d;
            bout_q  <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= ovf_d;
`endif
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Two instances of serial_subtractor: u_dut1 (WIDTH=8, BITS_PER_CYCLE=1) and
// u_dut4 (WIDTH=8, BITS_PER_CYCLE=4). A selector picks which one the tasks
// drive and observe. Expected results come from plain integer arithmetic on
// the operands and are queued in exp_q at acceptance.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- stimulus / DUT wiring ----------------
  logic         in_valid1, in_valid4;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_ready;

  logic         in_ready1, out_valid1, bout1, busy1;
  logic [W-1:0] diff1;
  logic         in_ready4, out_valid4, bout4, busy4;
  logic [W-1:0] diff4;
  logic         ovf1, ovf4;

  serial_subtractor #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid1), .out_ready(out_ready),
    .diff(diff1), .bout(bout1), .busy(busy1)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_subtractor #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid4), .out_ready(out_ready),
    .diff(diff4), .bout(bout4), .busy(busy4)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(ovf4)
`endif
  );

`ifndef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf1 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  // Observation mux: sel=0 -> u_dut1, sel=1 -> u_dut4
  logic         sel;
  logic         o_in_ready, o_out_valid, o_bout, o_busy, o_ovf;
  logic [W-1:0] o_diff;
  assign o_in_ready  = sel ? in_ready4  : in_ready1;
  assign o_out_valid = sel ? out_valid4 : out_valid1;
  assign o_bout      = sel ? bout4      : bout1;
  assign o_busy      = sel ? busy4      : busy1;
  assign o_diff      = sel ? diff4      : diff1;
  assign o_ovf       = sel ? ovf4       : ovf1;

  // ---------------- scoreboard ----------------
  // entry = {ovf, bout, diff}
  logic [W+1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic straight from a - b - bin.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int d, sd;
    logic [W-1:0] dl;
    logic uf, sovf;
    d    = int'(x) - int'(y) - int'(c);
    sd   = int'($signed(x)) - int'($signed(y)) - int'(c);
    dl   = d[W-1:0];
    uf   = (d < 0);
    sovf = (sd < -128) || (sd > 127);
    return {sovf, uf, dl};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_valid(input logic v);
    in_valid1 = sel ? 1'b0 : v;
    in_valid4 = sel ? v : 1'b0;
  endtask

  // One full operation: accept, check latency/busy, check result, hold under
  // backpressure for 'hold' cycles while pulsing in_valid, then release.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input int hold, input int steps);
    int cyc;
    logic [W+1:0] e;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin;
    drive_valid(1'b1);
    check("in_ready_idle", o_in_ready, 1);
    exp_q.push_back(model(ta, tb_v, tbin));
    @(negedge clk);
    drive_valid(1'b0);
    // Operands change after acceptance; must not affect the result.
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    cyc = 0;
    while (!o_out_valid && cyc < 64) begin
      check("busy_run", o_busy, 1);
      check("in_ready_run", o_in_ready, 0);
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, steps);
    check("out_valid", o_out_valid, 1);
    e = exp_q.pop_front();
    check("diff", o_diff, e[W-1:0]);
    check("bout", o_bout, e[W]);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("ovf", o_ovf, e[W+1]);
`endif
    check("busy_done", o_busy, 0);
    check("in_ready_done", o_in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      drive_valid(1'b1);
      @(negedge clk);
      check("bp_out_valid", o_out_valid, 1);
      check("bp_diff", o_diff, e[W-1:0]);
      check("bp_bout", o_bout, e[W]);
      check("bp_in_ready", o_in_ready, 0);
    end
    drive_valid(1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", o_out_valid, 0);
    check("release_in_ready", o_in_ready, 1);
    check("retain_diff", o_diff, e[W-1:0]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic seen_valid;
    rst = 1'b1; sel = 1'b0;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state of both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_in_ready", o_in_ready, 1);
      check("rst_out_valid", o_out_valid, 0);
      check("rst_busy", o_busy, 0);
      check("rst_diff", o_diff, 0);
      check("rst_bout", o_bout, 0);
      check("rst_ovf", o_ovf, 0);
    end

    // BPC=1 directed
    sel = 1'b0;
    run_op(8'h5A, 8'h3C, 1'b0, 0, 8);
    run_op(8'h00, 8'h01, 1'b0, 0, 8);
    run_op(8'h00, 8'h00, 1'b1, 0, 8);
    run_op(8'hFF, 8'hFF, 1'b0, 0, 8);
    run_op(8'h80, 8'h01, 1'b0, 0, 8);
    run_op(8'h7F, 8'hFF, 1'b0, 0, 8);
    run_op(8'h10, 8'h05, 1'b0, 0, 8);
    // Backpressure with in_valid pulses, then a clean follow-up
    run_op(8'hC3, 8'h4D, 1'b1, 5, 8);
    run_op(8'h21, 8'h12, 1'b0, 0, 8);

    // Reset in RUN at step 3
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0;
    drive_valid(1'b1);
    @(negedge clk);
    drive_valid(1'b0);
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", o_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out_valid", o_out_valid, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_in_ready", o_in_ready, 1);
    check("mid_rst_diff", o_diff, 0);
    check("mid_rst_bout", o_bout, 0);
    seen_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_valid = seen_valid | o_out_valid;
    end
    check("aborted_no_valid", seen_valid, 0);
    run_op(8'h10, 8'h01, 1'b0, 0, 8);

    // BPC=4 directed
    sel = 1'b1;
    run_op(8'hF0, 8'h0F, 1'b1, 0, 2);
    run_op(8'h00, 8'h01, 1'b0, 2, 2);

    // Random on both instances with random backpressure
    for (int i = 0; i < 200; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 2);
    end
    sel = 1'b0;
    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 8);
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
